sume_adder: RTL and testbench
=============================

# sume_adder

Sequential two-operand adder for the `sume` block. It collects two 12-bit operands from a 4-bit `sample` stream, one nibble per clock, most significant nibble first. It then registers their 12-bit sum. It sits behind a nibble/digit source such as a keypad scanner or serial loader, and feeds a display or downstream consumer that reads `w1`, `w2` and `sum`.

## Interface
- Parameters: none. The operand width is fixed at 12 bits (three 4-bit nibbles).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sample`  in  4  input nibble, consumed on every rising edge while not in reset.
- `w1`  out  12  first operand register.
- `w2`  out  12  second operand register.
- `sum`  out  12  result register, `w1 + w2` modulo 4096.

## Operation
- The FSM has 7 states: S0..S6. It advances one state per clock, unconditionally; there is no valid/ready handshake.
  - S0: `w1[11:8] <= sample`, then go to S1.
  - S1: `w1[7:4] <= sample`, then go to S2.
  - S2: `w1[3:0] <= sample`, then go to S3.
  - S3: `w2[11:8] <= sample`, then go to S4.
  - S4: `w2[7:4] <= sample`, then go to S5.
  - S5: `w2[3:0] <= sample`, then go to S6.
  - S6: `sum <= w1 + w2`; `sample` is ignored; go to S0.
- Arithmetic is plain binary, not BCD, 12 bits wide. The carry out is discarded, so results wrap around.
- The S6 addition uses the fully assembled `w1`/`w2`. S5 writes the last nibble one cycle earlier, so there is no bypass path.
- Operand registers are not cleared between operations. Each nibble keeps its old value until that nibble's state overwrites it.
- `sum` holds its value until the next S6.
- Reset values: state = S0; `w1` = 0x000; `w2` = 0x000; `sum` = 0x000.
- Reset mid-operation: an in-progress sequence is abandoned and all registers are cleared. The first edge after release loads `w1[11:8]`.

## Timing
- After reset is released, edges 1–3 load `w1`, edges 4–6 load `w2`, and edge 7 updates `sum`.
- `sum` is valid immediately after edge 7. Latency is 1 cycle from the last operand nibble to `sum`.
- Throughput is one addition per 7 clocks; the next sequence starts on edge 8 in S0.
- Each operand nibble (`w1`/`w2`) is visible on its output the cycle after it is captured.
- All outputs are registered, with no combinational path from `sample` to any output.
- `sample` must be stable around each rising edge.

## Structure
- Shared package `sume_pkg` holds:
  - `typedef enum logic [2:0] {S0..S6} sume_state_t`;
  - constants `NIB_W = 4`, `OP_W = 12`.
- One natural sub-module, `sume_fsm`: state register plus next-state logic, with a one-hot state decode output.
- Top level `sume` owns the nibble-write enables, the `w1`/`w2` registers and the adder/`sum` register.

## Test plan
- Reset is held: `w1`, `w2`, `sum` = 0x000. Release, then first edge with `sample` = 0x0 → `w1[11:8]` = 0x0.
- Basic sequence 0,7,3,2,4,7,0 after reset → `w1` = 0x073 (115), `w2` = 0x247 (583), `sum` = 0x2BA (698) right after edge 7.
- Overflow: `w1` = 0xFFF, `w2` = 0x001 (digits F,F,F,0,0,1,x) → `sum` = 0x000. `w1` = 0x800, `w2` = 0x800 → `sum` = 0x000.
- Back-to-back: the basic sequence, then 1,2,3,4,5,6,x → second `sum` = 0x579. Between the two S6 edges, `sum` holds 0x2BA.
- Reset mid-operation: assert reset asynchronously after 4 nibbles, between edges → `w1`, `w2`, `sum` = 0x000 immediately. After release, 0,7,3,2,4,7,0 → `sum` = 0x2BA.
- S6 ignores input: drive `sample` = 0xF in S6 → `w1`/`w2` unchanged, and the next S0 edge loads `w1[11:8]` from the new `sample`.

Source files
------------

// File: rtl/sume_pkg.sv
// Shared types and constants for the sume nibble-serial adder.
package sume_pkg;

    localparam int NIB_W      = 4;
    localparam int OP_W       = 12;
    localparam int NUM_STATES = 7;

    // S0..S2 load w1 nibbles (MS first), S3..S5 load w2 nibbles, S6 adds.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } sume_state_t;

    // Successor of a state in the fixed seven-step cycle.
    function automatic sume_state_t next_state(input sume_state_t s);
        sume_state_t n;
        case (s)
            S0:      n = S1;
            S1:      n = S2;
            S2:      n = S3;
            S3:      n = S4;
            S4:      n = S5;
            S5:      n = S6;
            default: n = S0;  // S6 wraps; the unused encoding recovers to S0
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sume_if.sv
// Nibble input and operand/result outputs of the sume adder.
interface sume_if;
    import sume_pkg::*;

    logic [NIB_W-1:0] sample;
    logic [OP_W-1:0]  w1;
    logic [OP_W-1:0]  w2;
    logic [OP_W-1:0]  sum;

    // The nibble source drives sample and observes the registers.
    modport master (output sample, input w1, input w2, input sum);
    // The adder consumes sample and presents the registers.
    modport slave  (input sample, output w1, output w2, output sum);

endinterface

// File: rtl/sume_fsm.sv
// Free-running seven-state sequencer with a one-hot state decode.
module sume_fsm
    import sume_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    output logic [NUM_STATES-1:0] state_oh
);

    sume_state_t state_q;
    sume_state_t state_d;

    // State register: advances every clock, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: unconditional step through the cycle.
    always_comb begin
        state_d = next_state(state_q);
    end

    // Output decode: one bit per state for the datapath enables.
    always_comb begin
        // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
        state_oh = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            state_oh[i] = (int'(state_q) == i);
        end
    end

endmodule

// File: rtl/sume_adder.sv
// Collects two 12-bit operands one nibble per clock and registers their sum.
module sume_adder
    import sume_pkg::*;
(
    input  logic clk,
    input  logic reset,
    sume_if.slave bus
);

    logic [NUM_STATES-1:0] state_oh;
    logic [OP_W-1:0]       w1_q;
    logic [OP_W-1:0]       w2_q;
    logic [OP_W-1:0]       sum_q;

    // Nibble-write enables, one per operand nibble, from the state decode.
    logic w1_hi_en, w1_mid_en, w1_lo_en;
    logic w2_hi_en, w2_mid_en, w2_lo_en;
    logic sum_en;

    sume_fsm u_fsm (
        .clk      (clk),
        .reset    (reset),
        .state_oh (state_oh)
    );

    // Enable decode: each state owns exactly one register slice.
    always_comb begin
        w1_hi_en  = state_oh[int'(S0)];
        w1_mid_en = state_oh[int'(S1)];
        w1_lo_en  = state_oh[int'(S2)];
        w2_hi_en  = state_oh[int'(S3)];
        w2_mid_en = state_oh[int'(S4)];
        w2_lo_en  = state_oh[int'(S5)];
        sum_en    = state_oh[int'(S6)];
    end

    // Operand registers: nibbles not addressed this cycle keep their old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w1_q <= '0;
            w2_q <= '0;
        end else begin
            if (w1_hi_en)  w1_q[11:8] <= bus.sample;
            if (w1_mid_en) w1_q[7:4]  <= bus.sample;
            if (w1_lo_en)  w1_q[3:0]  <= bus.sample;
            if (w2_hi_en)  w2_q[11:8] <= bus.sample;
            if (w2_mid_en) w2_q[7:4]  <= bus.sample;
            if (w2_lo_en)  w2_q[3:0]  <= bus.sample;
        end
    end

    // Result register: modulo-4096 sum of the fully assembled operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (sum_en) begin
            sum_q <= w1_q + w2_q;
        end
    end

    assign bus.w1  = w1_q;
    assign bus.w2  = w2_q;
    assign bus.sum = sum_q;

endmodule

// File: tb/tb_sume_adder.sv
// Self-checking bench for sume_adder: vector table, corner sequences, random traffic.
module tb_sume_adder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sume_if bus ();

    sume_adder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: seven-step cycle over a list of six captured digits.
    int         m_phase;
    logic [3:0] m_dig [6];
    int         m_sum;

    function automatic int m_w1();
        return m_dig[0] * 256 + m_dig[1] * 16 + m_dig[2];
    endfunction

    function automatic int m_w2();
        return m_dig[3] * 256 + m_dig[4] * 16 + m_dig[5];
    endfunction

    task automatic model_reset();
        m_phase = 0;
        for (int i = 0; i < 6; i++) m_dig[i] = 4'h0;
        m_sum = 0;
    endtask

    task automatic model_edge(input logic [3:0] s);
        if (m_phase < 6) m_dig[m_phase] = s;
        else             m_sum = (m_w1() + m_w2()) % 4096;
        m_phase = (m_phase + 1) % 7;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one nibble, clock it in, then compare all outputs against the model.
    task automatic step(input logic [3:0] s);
        bus.sample = s;
        @(posedge clk);
        model_edge(s);
        #1;
        check("w1_model",  bus.w1,  12'(m_w1()));
        check("w2_model",  bus.w2,  12'(m_w2()));
        check("sum_model", bus.sum, 12'(m_sum));
    endtask

    typedef struct {
        string       name;
        logic [27:0] digits;  // seven nibbles, first-applied in the top nibble
        logic [11:0] w1;
        logic [11:0] w2;
        logic [11:0] sum;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vector(input int k);
        logic [11:0] prev_sum;
        prev_sum = bus.sum;
        for (int d = 0; d < 6; d++) step(vecs[k].digits[27 - 4*d -: 4]);
        check({vecs[k].name, "_w1"}, bus.w1, vecs[k].w1);
        check({vecs[k].name, "_w2"}, bus.w2, vecs[k].w2);
        check({vecs[k].name, "_sum_hold"}, bus.sum, prev_sum);
        step(vecs[k].digits[3:0]);
        check({vecs[k].name, "_sum"}, bus.sum, vecs[k].sum);
    endtask

    initial begin
        logic [11:0] keep_w1;
        logic [11:0] keep_w2;

        checks = 0;
        errors = 0;

        vecs[0] = '{"basic",    28'h0732470, 12'h073, 12'h247, 12'h2BA};
        vecs[1] = '{"ovf_fff",  28'hFFF0015, 12'hFFF, 12'h001, 12'h000};
        vecs[2] = '{"ovf_800",  28'h8008003, 12'h800, 12'h800, 12'h000};
        vecs[3] = '{"basic2",   28'h0732470, 12'h073, 12'h247, 12'h2BA};
        vecs[4] = '{"b2b",      28'h123456A, 12'h123, 12'h456, 12'h579};

        // Reset held: all registers clear.
        reset      = 1'b1;
        bus.sample = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_w1",  bus.w1,  12'h000);
        check("rst_w2",  bus.w2,  12'h000);
        check("rst_sum", bus.sum, 12'h000);
        reset = 1'b0;

        // Table vectors; 3 and 4 run back to back so sum holds 0x2BA between adds.
        for (int k = 0; k < 5; k++) run_vector(k);

        // Reset mid-operation after four nibbles, asserted between edges.
        for (int d = 1; d <= 4; d++) step(4'(d + 8));
        #2;
        reset = 1'b1;
        #1;
        check("midrst_w1",  bus.w1,  12'h000);
        check("midrst_w2",  bus.w2,  12'h000);
        check("midrst_sum", bus.sum, 12'h000);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_vector(0);

        // S6 ignores sample; next S0 edge takes the new nibble into w1[11:8].
        for (int d = 0; d < 6; d++) step(4'($urandom_range(0, 15)));
        keep_w1 = bus.w1;
        keep_w2 = bus.w2;
        step(4'hF);
        check("s6_w1_keep", bus.w1, keep_w1);
        check("s6_w2_keep", bus.w2, keep_w2);
        step(4'h9);
        check("s0_w1_hi", {8'h00, bus.w1[11:8]}, 12'h009);
        check("s0_w1_rest", {4'h0, bus.w1[7:0]}, {4'h0, keep_w1[7:0]});
        for (int d = 0; d < 6; d++) step(4'($urandom_range(0, 15)));

        // Random traffic against the model.
        for (int n = 0; n < 30 * 7; n++) step(4'($urandom_range(0, 15)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
